// File: rtl/service_packet_pkg.sv
// Shared types and helpers for the service packet encoder.
// Holds the FSM state enum, the header builder and the CRC-16-CCITT step.
package service_packet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    HDR,
    SIZE,
    DATA,
    CSUM,
    DROP
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Header word before zero-extension: device address over channel index.
  function automatic logic [15:0] build_header(input logic [7:0] addr, input logic [7:0] chan);
    return {addr, chan};
  endfunction

  // Fold one 16-bit word into a CRC-16-CCITT register, MSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC16_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/service_packet_buffer.sv
// Simple dual-port packet RAM, one write port and one registered read port.
// Contents are not reset; a packet is always rewritten before it is read.
module service_packet_buffer #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write on enable; read every cycle so rd_data tracks the presented address.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/service_packet_encoder.sv
// Service packet encoder: round-robin collects one packet from CHANNELS
// sources into a buffer, then emits header, size, payload and checksum.
// Build option: define SERVICE_PACKET_CRC16_EN to replace the additive
// checksum with CRC-16-CCITT over the low 16 bits of each emitted word.
module service_packet_encoder
  import service_packet_pkg::*;
#(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 cfg_addr,
  input  logic [CHANNELS*WORD_W-1:0] in_data,
  input  logic [CHANNELS-1:0]        in_valid,
  input  logic [CHANNELS-1:0]        in_last,
  output logic [CHANNELS-1:0]        in_ready,
  output logic [WORD_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       overflow
);

  localparam int unsigned AW    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int unsigned CNT_W = AW + 1;
  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_WORDS);

`ifdef SERVICE_PACKET_CRC16_EN
  localparam logic [WORD_W-1:0] CSUM_INIT = WORD_W'(CRC16_INIT);
`else
  localparam logic [WORD_W-1:0] CSUM_INIT = '0;
`endif

  // Running checksum update with one emitted word.
  function automatic logic [WORD_W-1:0] csum_step(input logic [WORD_W-1:0] acc,
                                                  input logic [WORD_W-1:0] word);
`ifdef SERVICE_PACKET_CRC16_EN
    return WORD_W'(crc16_step(acc[15:0], word[15:0]));
`else
    return acc + word;
`endif
  endfunction

  state_t            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   rr_pick;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0] csum_q, csum_d, csum_nxt;
  logic [CHANNELS-1:0] in_ready_d;
  logic [WORD_W-1:0] out_data_d;
  logic              out_valid_d, busy_d, overflow_d;
  logic [WORD_W-1:0] sel_data;
  logic              sel_last;
  logic              accept, fire, wr_en;
  logic [WORD_W-1:0] rd_data;

  service_packet_buffer #(
    .WORD_W (WORD_W),
    .DEPTH  (MAX_WORDS),
    .ADDR_W (AW)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (sel_data),
    .rd_addr (rd_ptr_d),
    .rd_data (rd_data)
  );

  // Round-robin pick of the first requesting channel after the last grant.
  always_comb begin
    int unsigned idx;
    logic        found;
    rr_pick = rr_q;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      idx = (32'(rr_q) + i) % CHANNELS;
      if (!found && in_valid[CH_W'(idx)]) begin
        rr_pick = CH_W'(idx);
        found   = 1'b1;
      end
    end
  end

  // Payload word and last flag of the granted channel.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (CH_W'(c) == grant_q) begin
        sel_data = in_data[c*WORD_W +: WORD_W];
        sel_last = in_last[c];
      end
    end
  end

  assign accept   = |(in_valid & in_ready);
  assign fire     = out_valid & out_ready;
  assign csum_nxt = csum_step(csum_q, out_data);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    csum_d      = csum_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    overflow_d  = 1'b0;
    wr_en       = 1'b0;
    in_ready_d  = '0;

    case (state_q)
      IDLE: begin
        count_d  = '0;
        rd_ptr_d = '0;
        csum_d   = CSUM_INIT;
        if (|in_valid) begin
          grant_d = rr_pick;
          rr_d    = rr_pick;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (count_q == FULL) begin
            // No room for this word: the packet cannot be encoded.
            if (sel_last) begin
              overflow_d = 1'b1;
              state_d    = IDLE;
            end else begin
              state_d = DROP;
            end
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + CNT_W'(1);
            if (sel_last) begin
              state_d     = HDR;
              out_valid_d = 1'b1;
              out_data_d  = WORD_W'(build_header(cfg_addr, 8'(grant_q)));
            end
          end
        end
      end
      HDR: begin
        if (fire) begin
          csum_d     = csum_nxt;
          out_data_d = WORD_W'(count_q);
          state_d    = SIZE;
        end
      end
      SIZE: begin
        if (fire) begin
          csum_d     = csum_nxt;
          out_data_d = rd_data;
          rd_ptr_d   = rd_ptr_q + AW'(1);
          state_d    = DATA;
        end
      end
      DATA: begin
        if (fire) begin
          csum_d = csum_nxt;
          if (count_q == CNT_W'(1)) begin
            out_data_d = csum_nxt;
            state_d    = CSUM;
          end else begin
            out_data_d = rd_data;
            rd_ptr_d   = rd_ptr_q + AW'(1);
            count_d    = count_q - CNT_W'(1);
          end
        end
      end
      CSUM: begin
        if (fire) begin
          out_valid_d = 1'b0;
          out_data_d  = '0;
          state_d     = IDLE;
        end
      end
      DROP: begin
        if (accept && sel_last) begin
          overflow_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == COLLECT || state_d == DROP) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        in_ready_d[c] = (CH_W'(c) == grant_d);
      end
    end
    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= CH_W'(CHANNELS - 1);
      count_q   <= '0;
      rd_ptr_q  <= '0;
      csum_q    <= '0;
      in_ready  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      csum_q    <= csum_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      busy      <= busy_d;
      overflow  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_service_packet_encoder.sv
// Self-checking bench for service_packet_encoder: directed cases plus
// randomized packets compared against a packet-level reference model.
module tb_service_packet_encoder;

  localparam int W  = 16;
  localparam int CH = 2;
  localparam int MW = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [7:0]      cfg_addr = 8'hAB;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_last;
  logic [CH-1:0]   in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            overflow;

  service_packet_encoder #(
    .WORD_W    (W),
    .CHANNELS  (CH),
    .MAX_WORDS (MW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_addr  (cfg_addr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-channel source queues of {last, data}, shared with the model.
  logic [W:0]   dq [CH][$];
  logic [CH-1:0] acc = '0;
  bit           rand_ready = 1'b0;

  // Observed stream and timing.
  int           cyc = 0;
  logic [W-1:0] got_q[$];
  int           hs_cyc[$];
  int           acc_cyc[$];
  int           ovf_cnt = 0;
  logic         stall_prev = 1'b0;
  logic [W-1:0] data_prev = '0;

  // Reference model state.
  logic [W-1:0] m_words [CH][$];
  int           m_len   [CH][$];
  int           m_last = CH - 1;
  logic [W-1:0] exp_q[$];
  int           exp_ovf = 0;
  logic [W-1:0] pl[$];

  // Source driver: pop accepted words, present the next word of each channel.
  initial begin
    in_valid = '0;
    in_last  = '0;
    in_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
        logic [W:0] e;
        if (acc[c] && dq[c].size() > 0) void'(dq[c].pop_front());
        if (dq[c].size() > 0) begin
          e = dq[c][0];
          in_valid[c] = 1'b1;
          in_last[c]  = e[W];
          in_data[c*W +: W] = e[W-1:0];
        end else begin
          in_valid[c] = 1'b0;
          in_last[c]  = 1'b0;
        end
      end
    end
  end

  // Sink back-pressure.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor on the falling edge: handshakes, stalls, overflow pulses.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        acc        = '0;
        stall_prev = 1'b0;
      end else begin
        acc = in_valid & in_ready;
        if (|acc) acc_cyc.push_back(cyc);
        if (stall_prev) begin
          check_eq("stall_valid", 32'(out_valid), 32'd1);
          check_eq("stall_data", 32'(out_data), 32'(data_prev));
        end
        if (out_valid && out_ready) begin
          got_q.push_back(out_data);
          hs_cyc.push_back(cyc);
        end
        if (overflow) ovf_cnt++;
        stall_prev = out_valid && !out_ready;
        data_prev  = out_data;
      end
    end
  end

  function automatic logic [W-1:0] ref_csum(input logic [W-1:0] s[$]);
`ifdef SERVICE_PACKET_CRC16_EN
    bit          bits[$];
    logic [15:0] crc;
    crc = 16'hFFFF;
    foreach (s[k]) for (int b = 15; b >= 0; b--) bits.push_back(s[k][b]);
    foreach (bits[k]) begin
      if (crc[15] ^ bits[k]) crc = {crc[14:0], 1'b0} ^ 16'h1021;
      else                   crc = {crc[14:0], 1'b0};
    end
    return W'(crc);
`else
    int unsigned a;
    a = 0;
    foreach (s[k]) a += 32'(s[k]);
    return W'(a % 65536);
`endif
  endfunction

  // Queue the packet held in pl on channel c, for both driver and model.
  task automatic add_pkt(input int c);
    foreach (pl[k]) begin
      dq[c].push_back({(k == pl.size() - 1), pl[k]});
      m_words[c].push_back(pl[k]);
    end
    m_len[c].push_back(pl.size());
  endtask

  task automatic rand_pl(input int len);
    pl.delete();
    for (int k = 0; k < len; k++) pl.push_back(W'($urandom));
  endtask

  // Packet-level round-robin service of everything queued, building exp_q.
  task automatic run_model(input logic [7:0] addr);
    int found;
    int len;
    logic [W-1:0] seq[$];
    forever begin
      found = -1;
      for (int i = 1; i <= CH; i++) begin
        int c;
        c = (m_last + i) % CH;
        if (found < 0 && m_len[c].size() > 0) found = c;
      end
      if (found < 0) break;
      m_last = found;
      len = m_len[found].pop_front();
      seq.delete();
      seq.push_back({addr, 8'(found)});
      seq.push_back(W'(len));
      for (int k = 0; k < len; k++) seq.push_back(m_words[found].pop_front());
      if (len > MW) exp_ovf++;
      else begin
        foreach (seq[k]) exp_q.push_back(seq[k]);
        exp_q.push_back(ref_csum(seq));
      end
    end
  endtask

  task automatic start_scn();
    got_q.delete();
    exp_q.delete();
    hs_cyc.delete();
    acc_cyc.delete();
    ovf_cnt = 0;
    exp_ovf = 0;
  endtask

  task automatic flush_all();
    for (int c = 0; c < CH; c++) begin
      dq[c].delete();
      m_words[c].delete();
      m_len[c].delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush_all();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_last = CH - 1;
  endtask

  // Wait for sources drained and encoder idle, then compare against the model.
  task automatic wait_compare(input string tag, input int budget);
    int n;
    int quiet;
    bit empty;
    n = 0;
    quiet = 0;
    while (n < budget && quiet < 4) begin
      @(negedge clk);
      n++;
      empty = 1'b1;
      for (int c = 0; c < CH; c++) if (dq[c].size() > 0) empty = 1'b0;
      if (empty && !busy && !out_valid) quiet++;
      else quiet = 0;
    end
    check_eq({tag, "_done"}, 32'(quiet >= 4), 32'd1);
    check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check_eq({tag, "_ovf"}, 32'(ovf_cnt), 32'(exp_ovf));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    logic [7:0]   a;
    int           n;

    // Reset values while rst is held low.
    #12;
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    do_reset();

    // Two-word packet with known checksum and back-to-back timing.
    start_scn();
    cfg_addr = 8'hAB;
    pl.delete();
    pl.push_back(16'hEFAB);
    pl.push_back(16'h0001);
    add_pkt(0);
    run_model(8'hAB);
    wait_compare("basic", 200);
    v = (got_q.size() > 4) ? got_q[4] : 16'h0;
`ifdef SERVICE_PACKET_CRC16_EN
    check_eq("basic_crc", 32'(v), 32'(ref_csum('{16'hAB00, 16'h0002, 16'hEFAB, 16'h0001})));
`else
    check_eq("basic_sum", 32'(v), 32'h9AAE);
`endif
    v = (got_q.size() > 0) ? got_q[0] : 16'h0;
    check_eq("basic_hdr", 32'(v), 32'hAB00);
    if (hs_cyc.size() == 5 && acc_cyc.size() == 2) begin
      check_eq("hdr_latency", 32'(hs_cyc[0] - acc_cyc[1]), 32'd1);
      check_eq("out_burst", 32'(hs_cyc[4] - hs_cyc[0]), 32'd4);
    end else begin
      check_eq("timing_samples", 32'(hs_cyc.size()), 32'd5);
    end

    // Simultaneous requests after reset: channel 0 first, then channel 1.
    do_reset();
    start_scn();
    rand_pl(3);
    add_pkt(0);
    rand_pl(2);
    add_pkt(1);
    run_model(8'hAB);
    wait_compare("arb", 300);
    v = (got_q.size() > 6) ? got_q[6] : 16'hFFFF;
    check_eq("arb_ch1_hdr", 32'(v[7:0]), 32'h01);
    v = (got_q.size() > 0) ? got_q[0] : 16'hFFFF;
    check_eq("arb_ch0_hdr", 32'(v[7:0]), 32'h00);

    // Oversized packet is dropped with one overflow pulse.
    start_scn();
    rand_pl(MW + 3);
    add_pkt(0);
    run_model(8'hAB);
    wait_compare("drop", 400);
    check_eq("drop_busy", 32'(busy), 32'd0);

    // Random back-pressure on a five-word packet.
    start_scn();
    rand_ready = 1'b1;
    rand_pl(5);
    add_pkt(1);
    run_model(8'hAB);
    wait_compare("stall", 400);
    rand_ready = 1'b0;

    // Reset in the middle of the payload, then a clean packet.
    start_scn();
    rand_pl(10);
    add_pkt(0);
    n = 0;
    while (got_q.size() < 4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_reach_data", 32'(got_q.size() >= 4), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("mid_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_out_data", 32'(out_data), 32'd0);
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_in_ready", 32'(in_ready), 32'd0);
    check_eq("mid_overflow", 32'(overflow), 32'd0);
    do_reset();
    start_scn();
    rand_pl(4);
    add_pkt(1);
    run_model(8'hAB);
    wait_compare("after_rst", 300);

    // Randomized batches on all channels, including boundary lengths.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      start_scn();
      rand_ready = (r % 2) == 1;
      a = 8'($urandom);
      cfg_addr = a;
      for (int c = 0; c < CH; c++) begin
        int npk;
        npk = $urandom_range(1, 2);
        for (int k = 0; k < npk; k++) begin
          int sel;
          int len;
          sel = $urandom_range(0, 9);
          if (sel == 0)      len = 1;
          else if (sel == 1) len = MW;
          else if (sel == 2) len = MW + 2 + $urandom_range(0, 3);
          else               len = $urandom_range(1, 12);
          rand_pl(len);
          add_pkt(c);
        end
      end
      run_model(a);
      wait_compare($sformatf("rnd%0d", r), 6000);
    end
    rand_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
